// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use stall control for the 5-stage RV32IC pipeline.
// Define HAZ_STATS_EN to add the stall_cycles / load_use_events statistics outputs.
module hazard_forward_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   if_id_rs,
    input  logic [NUM_SRC-1:0]          if_id_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0]   id_ex_rs,
    input  logic [REG_AW-1:0]           id_ex_rd,
    input  logic                        id_ex_regwrite,
    input  logic                        id_ex_memread,
    input  logic [REG_AW-1:0]           ex_mem_rd,
    input  logic                        ex_mem_regwrite,
    input  logic                        ex_mem_memread,
    input  logic [REG_AW-1:0]           mem_wb_rd,
    input  logic                        mem_wb_regwrite,
    input  logic                        flush,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        pc_stall,
    output logic                        if_id_stall,
    output logic                        id_ex_bubble,
    output logic                        stall_active
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 load_use_events
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_hit;
    logic             detect;
    logic             stall;

    // EX/MEM is checked first so the newest value wins; loads in MEM have no data yet.
    always_comb begin
        fwd_sel = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_ex_rs[i*REG_AW +: REG_AW] != '0) begin
                    if (ex_mem_regwrite && !ex_mem_memread &&
                        ex_mem_rd == id_ex_rs[i*REG_AW +: REG_AW]) begin
                        fwd_sel[2*i +: 2] = 2'b10;
                    end else if (mem_wb_regwrite &&
                                 mem_wb_rd == id_ex_rs[i*REG_AW +: REG_AW]) begin
                        fwd_sel[2*i +: 2] = 2'b01;
                    end
                end
            end
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_hit = rs_hit | (if_id_rs_used[i] && (if_id_rs[i*REG_AW +: REG_AW] == id_ex_rd));
        end
        detect = id_ex_memread && id_ex_regwrite && (id_ex_rd != '0) && rs_hit;
    end

    // The first bubble is issued from IDLE, so STALL only covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_STALL) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
            end
        end else if (detect && (LOAD_LAT > 1)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall = !rst && !flush &&
                   (((state_q == ST_IDLE) && detect) || (state_q == ST_STALL));

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign id_ex_bubble = stall;
    assign stall_active = (state_q == ST_STALL);

`ifdef HAZ_STATS_EN
    logic hazard_accept;
    assign hazard_accept = (state_q == ST_IDLE) && detect && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles    <= '0;
            load_use_events <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (hazard_accept && (load_use_events != '1)) begin
                load_use_events <= load_use_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: LOAD_LAT=1 and LOAD_LAT=3 instances on shared stimulus,
// checked every cycle against a remaining-bubble model plus directed literal checks.
module tb_hazard_forward_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned NS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS*AW-1:0] if_id_rs;
    logic [NS-1:0]    if_id_rs_used;
    logic [NS*AW-1:0] id_ex_rs;
    logic [AW-1:0]    id_ex_rd;
    logic             id_ex_regwrite, id_ex_memread;
    logic [AW-1:0]    ex_mem_rd;
    logic             ex_mem_regwrite, ex_mem_memread;
    logic [AW-1:0]    mem_wb_rd;
    logic             mem_wb_regwrite;
    logic             flush;

    logic [NS*2-1:0]  fwd1, fwd3;
    logic             pcs1, ifs1, bub1, act1;
    logic             pcs3, ifs3, bub3, act3;
`ifdef HAZ_STATS_EN
    logic [31:0]      sc1, ev1, sc3, ev3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: bubbles still owed after the current cycle.
    int rem1 = 0;
    int rem3 = 0;
    int m_sc = 0;
    int m_ev = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
        .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .flush(flush),
        .fwd_sel(fwd1), .pc_stall(pcs1), .if_id_stall(ifs1), .id_ex_bubble(bub1),
        .stall_active(act1)
`ifdef HAZ_STATS_EN
        , .stall_cycles(sc1), .load_use_events(ev1)
`endif
    );

    hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
        .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .flush(flush),
        .fwd_sel(fwd3), .pc_stall(pcs3), .if_id_stall(ifs3), .id_ex_bubble(bub3),
        .stall_active(act3)
`ifdef HAZ_STATS_EN
        , .stall_cycles(sc3), .load_use_events(ev3)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS*2-1:0] model_fwd();
        logic [NS*2-1:0] r;
        logic [AW-1:0]   rs;
        r = '0;
        if (rst) return r;
        for (int i = 0; i < NS; i++) begin
            rs = id_ex_rs[i*AW +: AW];
            if (rs == 0) r[2*i +: 2] = 2'b00;
            else if (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd == rs) r[2*i +: 2] = 2'b10;
            else if (mem_wb_regwrite && mem_wb_rd == rs) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic model_detect();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (if_id_rs_used[i] && if_id_rs[i*AW +: AW] == id_ex_rd) hit = 1'b1;
        end
        return id_ex_memread && id_ex_regwrite && (id_ex_rd != 0) && hit;
    endfunction

    function automatic int next_rem(input int rem, input int lat, input logic det);
        if (flush) return 0;
        if (rem > 0) return rem - 1;
        if (det) return lat - 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        logic det;
        det = model_detect();
        if (rst) begin
            rem1 = 0; rem3 = 0; m_sc = 0; m_ev = 0;
        end else begin
            if (!flush && (rem3 > 0 || det)) m_sc++;
            if (!flush && rem3 == 0 && det) m_ev++;
            rem1 = next_rem(rem1, 1, det);
            rem3 = next_rem(rem3, 3, det);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic det, s1, s3;
        det = model_detect();
        s1 = !rst && !flush && (rem1 > 0 || det);
        s3 = !rst && !flush && (rem3 > 0 || det);
        check("fwd1", 64'(fwd1), 64'(model_fwd()));
        check("fwd3", 64'(fwd3), 64'(model_fwd()));
        check("stall1", 64'({pcs1, ifs1, bub1}), 64'({s1, s1, s1}));
        check("stall3", 64'({pcs3, ifs3, bub3}), 64'({s3, s3, s3}));
        check("active1", 64'(act1), 64'(!rst && rem1 > 0));
        check("active3", 64'(act3), 64'(!rst && rem3 > 0));
`ifdef HAZ_STATS_EN
        check("sc3", 64'(sc3), 64'(m_sc));
        check("ev3", 64'(ev3), 64'(m_ev));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_id_rs = '0; if_id_rs_used = '0; id_ex_rs = '0; id_ex_rd = '0;
        id_ex_regwrite = 0; id_ex_memread = 0; ex_mem_rd = '0; ex_mem_regwrite = 0;
        ex_mem_memread = 0; mem_wb_rd = '0; mem_wb_regwrite = 0; flush = 0;
    endtask

    task automatic load_use_on();
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 5'd3;
        if_id_rs = {5'd0, 5'd3}; if_id_rs_used = 2'b01;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        // Reset forces fwd_sel low even with a live match.
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1; id_ex_rs = {5'd5, 5'd5};
        #2;
        check("rst_fwd", 64'(fwd1), 64'(0));
        check("rst_stall", 64'({pcs3, act3}), 64'(0));
        step(); step();
        rst = 0;

        // Priority
        mem_wb_rd = 5'd5; mem_wb_regwrite = 1;
        @(negedge clk);
        check("prio_both", 64'(fwd1), 64'(4'b1010));
        step();
        ex_mem_regwrite = 0;
        @(negedge clk);
        check("prio_wb", 64'(fwd1), 64'(4'b0101));
        step();

        // x0 and load filter
        clear_inputs();
        ex_mem_rd = 5'd7; ex_mem_regwrite = 1; ex_mem_memread = 1;
        mem_wb_rd = 5'd7; mem_wb_regwrite = 1;
        id_ex_rs = {5'd7, 5'd0};
        @(negedge clk);
        check("x0_load", 64'(fwd1), 64'(4'b0100));
        step();

        // Load-use single pulse
        clear_inputs();
        load_use_on();
        @(negedge clk);
        check("lu_c1_l1", 64'({pcs1, act1}), 64'(2'b10));
        check("lu_c1_l3", 64'({pcs3, act3}), 64'(2'b10));
        step();
        clear_inputs();
        @(negedge clk);
        check("lu_c2_l1", 64'({pcs1, act1}), 64'(2'b00));
        check("lu_c2_l3", 64'({pcs3, act3}), 64'(2'b11));
        step();
        @(negedge clk);
        check("lu_c3_l3", 64'({pcs3, act3}), 64'(2'b11));
        step();
        @(negedge clk);
        check("lu_c4_l3", 64'({pcs3, act3}), 64'(2'b00));
        step();

        // Unused operand does not stall
        load_use_on();
        if_id_rs_used = 2'b00;
        @(negedge clk);
        check("lu_unused", 64'({pcs1, pcs3}), 64'(0));
        step();

        // Flush in second stall cycle
        load_use_on();
        step();
        clear_inputs();
        flush = 1;
        @(negedge clk);
        check("flush_c2", 64'(pcs3), 64'(0));
        step();
        flush = 0;
        @(negedge clk);
        check("flush_c3", 64'({pcs3, act3}), 64'(0));
        step();

        // Reset mid-stall
        load_use_on();
        step();
        clear_inputs();
        #2;
        rst = 1;
        #1;
        check("rst_async", 64'({pcs3, ifs3, bub3, act3}), 64'(0));
        step();
        rst = 0;
        @(negedge clk);
        check("rst_after", 64'({pcs3, act3}), 64'(0));
        step();

`ifdef HAZ_STATS_EN
        rst = 1;
        step();
        rst = 0;
        load_use_on();
        step();
        clear_inputs();
        flush = 1;
        step();
        flush = 0;
        load_use_on();
        step();
        clear_inputs();
        step(); step(); step();
        check("stat_events", 64'(ev3), 64'(2));
        check("stat_cycles", 64'(sc3), 64'(4));
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            if_id_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if_id_rs_used   = 2'($urandom);
            id_ex_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_ex_rd        = 5'($urandom_range(0, 7));
            id_ex_regwrite  = ($urandom_range(0, 3) != 0);
            id_ex_memread   = ($urandom_range(0, 2) == 0);
            ex_mem_rd       = 5'($urandom_range(0, 7));
            ex_mem_regwrite = 1'($urandom);
            ex_mem_memread  = ($urandom_range(0, 3) == 0);
            mem_wb_rd       = 5'($urandom_range(0, 7));
            mem_wb_regwrite = 1'($urandom);
            flush           = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised forwarding and hazard unit for the RV32IC 5-stage pipeline.
- Forwarding: selects operand sources for NUM_SRC EX-stage operands, with EX/MEM having priority over MEM/WB.
- Load-use hazards: detects them in ID and holds PC/IF-ID while inserting ID/EX bubbles for LOAD_LAT cycles, using a small stall FSM with a down-counter.
- Placement: sits beside the ID/EX pipeline register; its outputs drive the EX operand muxes and the pipeline-register enables.

Parameters:
- REG_AW, 5, register-address width (x0 is hardwired zero).
- NUM_SRC, 2, source operands per instruction (2 for base RV32I; 3 allowed for future R4-type ops).
- LOAD_LAT, 1, bubble cycles per load-use hazard (>=1; >1 for slow data memory).
- CNT_W, 4, stall-counter width (must satisfy 2^CNT_W > LOAD_LAT).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_id_rs  in  NUM_SRC*REG_AW  source registers of the instruction in ID, packed (operand i at [i*REG_AW +: REG_AW])
- if_id_rs_used  in  NUM_SRC  operand i is actually read by the ID instruction
- id_ex_rs  in  NUM_SRC*REG_AW  source registers of the instruction in EX, packed
- id_ex_rd  in  REG_AW  destination register of the instruction in EX
- id_ex_regwrite  in  1  EX instruction writes the register file
- id_ex_memread  in  1  EX instruction is a load
- ex_mem_rd  in  REG_AW  destination register in MEM
- ex_mem_regwrite  in  1  MEM instruction writes the register file
- ex_mem_memread  in  1  MEM instruction is a load
- mem_wb_rd  in  REG_AW  destination register in WB
- mem_wb_regwrite  in  1  WB instruction writes the register file
- flush  in  1  taken branch/jump; squash IF/ID
- fwd_sel  out  NUM_SRC*2  per-operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_bubble  out  1  zero the control bits of ID/EX
- stall_active  out  1  FSM is in STALL (debug)

Behaviour:
Forwarding (combinational), evaluated per operand i:
- exm = ex_mem_regwrite & !ex_mem_memread & ex_mem_rd!=0 & ex_mem_rd==id_ex_rs[i]
- wbm = mem_wb_regwrite & mem_wb_rd!=0 & mem_wb_rd==id_ex_rs[i]
- fwd_sel[i] = exm ? 10 : wbm ? 01 : 00
- Both match: EX/MEM wins (newest value).
- Operands with rs==0: always 00.
- A load in EX/MEM never forwards from EX/MEM.
- Operands are independent; any mix of selects is legal.

Load-use detection (combinational):
- detect = id_ex_memread & id_ex_regwrite & id_ex_rd!=0 & OR over i of (if_id_rs_used[i] & if_id_rs[i]==id_ex_rd)

Stall FSM, states IDLE and STALL, with counter cnt[CNT_W-1:0]:
- IDLE, detect & !flush: stall outputs high this cycle. If LOAD_LAT>1, load cnt=LOAD_LAT-1 and go to STALL; otherwise stay IDLE.
- STALL: stall outputs high and cnt decrements each cycle. When cnt==1, go to IDLE on the next edge. Total asserted cycles = LOAD_LAT exactly.
- STALL: new detects are ignored; the pipeline is frozen, so the same hazard is not re-counted.
- flush in any state: stall outputs low that cycle, next state IDLE, cnt cleared. Flush dominates detect.
- pc_stall = if_id_stall = id_ex_bubble = (IDLE & detect & !flush) | (STALL & !flush).
- stall_active = (state==STALL).

Reset:
- rst asserted: state=IDLE, cnt=0, stall outputs and stall_active 0 immediately (asynchronous).
- fwd_sel forced to 0 while rst is high.
- Reset during STALL aborts the stall with no residual bubble after release.

Optional Feature:
HAZ_STATS_EN
- Defined: adds outputs stall_cycles[31:0] and load_use_events[31:0].
  - stall_cycles increments each cycle pc_stall=1.
  - load_use_events increments on each IDLE detect & !flush.
  - Both saturate at 0xFFFFFFFF, reset to 0 on rst, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- EX/MEM vs MEM/WB priority: ex_mem_rd=5 (regwrite), mem_wb_rd=5 (regwrite), id_ex_rs0=5, id_ex_rs1=5 -> fwd_sel=1010. Drop ex_mem_regwrite -> fwd_sel=0101.
- x0 and load filter: id_ex_rs0=0 with ex_mem_rd=0 -> 00. ex_mem_memread=1, ex_mem_rd=7=id_ex_rs1, mem_wb_rd=7 -> operand1=01.
- Load-use, LOAD_LAT=1: id_ex_memread, id_ex_rd=3, if_id_rs0=3 used -> stalls high for exactly 1 cycle, stall_active stays 0. Same with if_id_rs_used0=0 -> no stall.
- Load-use, LOAD_LAT=3: detect pulse for 1 cycle -> stalls high for exactly 3 consecutive cycles, stall_active high in cycles 2-3, then IDLE.
- Flush and reset: LOAD_LAT=3, flush asserted in 2nd stall cycle -> stalls low that cycle, no further stall. Repeat with rst pulse mid-stall -> outputs 0 asynchronously, IDLE after release.
- HAZ_STATS_EN: two LOAD_LAT=3 hazards, one flushed after 1 cycle -> load_use_events=2, stall_cycles=4.
